hjdebug_regarb: RTL and testbench
=================================

// Module: hjdebug_regarb
// PURPOSE
// Round-robin arbiter sharing one hjdebug-style register port (regreq/regwr/regaddr/regwdata ->
// regack/regerr/regrdata) between NREQ host-side requesters (e.g. JTAG bridge, soft CPU, UART shell).
// Serialises transactions, issues the single-cycle regreq pulse the slave expects, routes the response
// back to the owner, and converts a missing ack into an error response after a timeout.
// PARAMETERS
// NREQ     4    number of requesters (1..8)
// AW       12   register address width
// TIMEOUT  255  max cycles in WAIT before a forced error response (must exceed slave worst case, >=64)
// PORTS
// clk        in   1          clock
// rst        in   1          synchronous active-high reset
// m_req      in   NREQ       per-requester request, level, held until that requester's m_ack
// m_wr       in   NREQ       per-requester write flag, valid while m_req
// m_addr     in   NREQ*AW    per-requester address, slice i = [i*AW +: AW]
// m_wdata    in   NREQ*32    per-requester write data, slice i = [i*32 +: 32]
// m_ack      out  NREQ       one-cycle response strobe to the granted requester only
// m_err      out  1          error flag, valid with any m_ack bit
// m_rdata    out  32         read data, valid with any m_ack bit (broadcast)
// regreq     out  1          one-cycle request pulse to slave
// regwr      out  1          write flag to slave, held from ISSUE through WAIT
// regaddr    out  AW         address to slave, held from ISSUE through WAIT
// regwdata   out  32         write data to slave, held from ISSUE through WAIT
// regack     in   1          slave acknowledge pulse
// regerr     in   1          slave error, valid with regack
// regrdata   in   32         slave read data, valid with regack
// grant      out  3          index of current/last owner (debug)
// tmo_flag   out  1          sticky: set on any timeout, cleared by tmo_clr
// tmo_clr    in   1          clears tmo_flag (set wins if same cycle)
// BEHAVIOUR
// - All outputs registered. Reset: state IDLE, m_ack=0, m_err=0, m_rdata=0, regreq=0, regwr=0,
//   regaddr=0, regwdata=0, grant=0, tmo_flag=0, rr pointer=0, timeout counter=0.
// - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any m_req, pick first set bit scanning from (last grant+1) mod NREQ upward with wrap;
//     latch grant, regwr/regaddr/regwdata from that slice; go ISSUE. None set: stay.
//   ISSUE: regreq=1 for exactly this cycle; counter cleared; go WAIT.
//   WAIT: regack=1 -> capture regerr/regrdata into m_err/m_rdata, go RESP. Else count; counter reaching
//     TIMEOUT -> m_err=1, m_rdata=32'hDEADBEEF, tmo_flag=1, go RESP.
//   RESP: m_ack[grant]=1 for this cycle only; go IDLE. Requester drops m_req by the RESP-ending edge.
// - regack in ISSUE (same-cycle ack) is accepted exactly as in WAIT.
// - regack seen in IDLE/RESP (late ack after timeout or after reset) is discarded, no state change.
// - Latency: m_req seen in IDLE at edge t -> regreq high in cycle t+1; regack at edge a -> m_ack at a+1.
//   Minimum round trip with zero-wait slave: 4 cycles per transaction; back-to-back grants possible
//   from the IDLE cycle following RESP.
// - Fairness: requester just served has lowest priority next arbitration; with all NREQ requesting,
//   grants cycle 0,1,2,...,NREQ-1,0.
// - m_req dropping mid-transaction does not abort; response still issued to that index.
// - rst mid-transaction: immediate return to IDLE, no m_ack issued; downstream late ack discarded.
// - m_err/m_rdata hold last response value between acks.
// TESTING
// 1 Single req on port 2, read addr 0x004, slave acks 3 cycles later with 0x400 -> regreq 1 cycle,
//   regaddr=0x004, m_ack=4'b0100 one cycle after regack, m_rdata=0x400, m_err=0.
// 2 All four m_req high continuously, zero-wait slave -> grant sequence 0,1,2,3,0,1; one regreq per
//   4 cycles; never two regreq without intervening regack.
// 3 Slave never acks, TIMEOUT=255 -> m_ack[grant] at 257th cycle after regreq, m_err=1,
//   m_rdata=0xDEADBEEF, tmo_flag=1; tmo_clr pulse -> tmo_flag=0.
// 4 Ack arrives 10 cycles after timeout while IDLE with no requests -> no m_ack, state stays IDLE.
// 5 rst asserted in WAIT, slave acks 2 cycles later -> no m_ack, all outputs at reset values.
// 6 Write from port 1 (addr 0x014, data 0x5) while port 3 also requests -> port 1 first if last grant 0,
//   regwr=1, regwdata=5 stable ISSUE..WAIT; then port 3 served.

Source files
------------

// File: rtl/hjdebug_regarb.sv
// Round-robin arbiter sharing one register port between NREQ requesters, with ack timeout.
// Latency: regreq one cycle after m_req is seen in IDLE, m_ack one cycle after regack, 4-cycle min round trip.
// Backpressure: requesters hold m_req until their m_ack; one transaction in flight, never aborted once granted.
module hjdebug_regarb #(
   parameter int NREQ    = 4,
   parameter int AW      = 12,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    m_req,
   input  logic [NREQ-1:0]    m_wr,
   input  logic [NREQ*AW-1:0] m_addr,
   input  logic [NREQ*32-1:0] m_wdata,
   output logic [NREQ-1:0]    m_ack,
   output logic               m_err,
   output logic [31:0]        m_rdata,
   output logic               regreq,
   output logic               regwr,
   output logic [AW-1:0]      regaddr,
   output logic [31:0]        regwdata,
   input  logic               regack,
   input  logic               regerr,
   input  logic [31:0]        regrdata,
   output logic [2:0]         grant,
   output logic               tmo_flag,
   input  logic               tmo_clr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [2:0]      rr_ptr, rr_nx, grant_nx;
   logic [NREQ-1:0] m_ack_nx;
   logic            m_err_nx;
   logic [31:0]     m_rdata_nx;
   logic            regreq_nx, regwr_nx;
   logic [AW-1:0]   regaddr_nx;
   logic [31:0]     regwdata_nx;
   logic            tmo_nx;

   logic            arb_hit;
   logic [2:0]      arb_sel;
   int              arb_best;
   int              arb_dist;
   logic            sel_wr;
   logic [AW-1:0]   sel_addr;
   logic [31:0]     sel_wdata;
   logic [NREQ-1:0] owner_vec;

   // Pick the requesting port closest to rr_ptr, scanning upward with wrap.
   always_comb begin
      arb_hit  = 1'b0;
      arb_sel  = '0;
      arb_best = NREQ;
      arb_dist = 0;
      for (int j = 0; j < NREQ; j++) begin
         arb_dist = (j + NREQ - int'(rr_ptr)) % NREQ;
         if (m_req[j] && (arb_dist < arb_best)) begin
            arb_best = arb_dist;
            arb_sel  = 3'(j);
            arb_hit  = 1'b1;
         end
      end
   end

   // Route the winner's command fields and decode the current owner into a one-hot ack.
   always_comb begin
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      owner_vec = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (arb_sel == 3'(j)) begin
            sel_wr    = m_wr[j];
            sel_addr  = m_addr[j*AW +: AW];
            sel_wdata = m_wdata[j*32 +: 32];
         end
         owner_vec[j] = (grant == 3'(j));
      end
   end

   // Next-state and next-output logic; every output is registered from these values.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      rr_nx       = rr_ptr;
      grant_nx    = grant;
      m_ack_nx    = '0;
      m_err_nx    = m_err;
      m_rdata_nx  = m_rdata;
      regreq_nx   = 1'b0;
      regwr_nx    = regwr;
      regaddr_nx  = regaddr;
      regwdata_nx = regwdata;
      tmo_nx      = tmo_flag & ~tmo_clr;
      case (state)
         IDLE: begin
            // regack here is a stale ack from an abandoned transaction and is ignored
            if (arb_hit) begin
               state_nx    = ISSUE;
               grant_nx    = arb_sel;
               rr_nx       = 3'((int'(arb_sel) + 1) % NREQ);
               regreq_nx   = 1'b1;
               regwr_nx    = sel_wr;
               regaddr_nx  = sel_addr;
               regwdata_nx = sel_wdata;
            end
         end
         ISSUE: begin
            cnt_nx = '0;
            if (regack) begin
               state_nx   = RESP;
               m_ack_nx   = owner_vec;
               m_err_nx   = regerr;
               m_rdata_nx = regrdata;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (regack) begin
               state_nx   = RESP;
               m_ack_nx   = owner_vec;
               m_err_nx   = regerr;
               m_rdata_nx = regrdata;
            end else if (cnt == CW'(TIMEOUT)) begin
               state_nx   = RESP;
               m_ack_nx   = owner_vec;
               m_err_nx   = 1'b1;
               m_rdata_nx = 32'hDEADBEEF;
               tmo_nx     = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RESP: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rr_ptr   <= '0;
         grant    <= '0;
         m_ack    <= '0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
         regreq   <= 1'b0;
         regwr    <= 1'b0;
         regaddr  <= '0;
         regwdata <= '0;
         tmo_flag <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         rr_ptr   <= rr_nx;
         grant    <= grant_nx;
         m_ack    <= m_ack_nx;
         m_err    <= m_err_nx;
         m_rdata  <= m_rdata_nx;
         regreq   <= regreq_nx;
         regwr    <= regwr_nx;
         regaddr  <= regaddr_nx;
         regwdata <= regwdata_nx;
         tmo_flag <= tmo_nx;
      end
   end

endmodule

// File: tb/tb_hjdebug_regarb.sv
// Directed bench for hjdebug_regarb with queue-based scoreboards for issued commands and responses.
// Slave model returns rdata = addr << 8 and flags an error for address 0xFFC.
// Requesters raise m_req while they have outstanding work and retire one item per m_ack.
module tb_hjdebug_regarb;

   localparam int NREQ    = 4;
   localparam int AW      = 12;
   localparam int TIMEOUT = 255;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    m_req;
   logic [NREQ-1:0]    m_wr;
   logic [NREQ*AW-1:0] m_addr;
   logic [NREQ*32-1:0] m_wdata;
   logic [NREQ-1:0]    m_ack;
   logic               m_err;
   logic [31:0]        m_rdata;
   logic               regreq;
   logic               regwr;
   logic [AW-1:0]      regaddr;
   logic [31:0]        regwdata;
   logic               regack;
   logic               regerr;
   logic [31:0]        regrdata;
   logic [2:0]         grant;
   logic               tmo_flag;
   logic               tmo_clr;

   hjdebug_regarb #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
      .regreq(regreq), .regwr(regwr), .regaddr(regaddr), .regwdata(regwdata),
      .regack(regack), .regerr(regerr), .regrdata(regrdata),
      .grant(grant), .tmo_flag(tmo_flag), .tmo_clr(tmo_clr)
   );

   typedef struct {
      logic [2:0]  grant;
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          gap;
   } iss_t;

   typedef struct {
      logic [3:0]  ack;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } rsp_t;

   iss_t iss_q[$];
   rsp_t rsp_q[$];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int t_req       = 0;

   int issued [NREQ];
   int served [NREQ];
   int aborted[NREQ];

   int slv_delay = 1;
   bit slv_chk   = 1'b1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input logic [63:0] act);
      vectors++;
      miscompares++;
      $display("FAIL %s: got 0x%0h, required no such event (cycle %0d)", name, act, cyc);
   endtask

   function automatic bit pend_any();
      bit any = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (issued[i] != served[i] + aborted[i]) any = 1'b1;
      return any;
   endfunction

   task automatic req(input int port, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input int n);
      m_wr[port]            = wr;
      m_addr[port*AW +: AW] = addr;
      m_wdata[port*32 +: 32] = wdata;
      issued[port]          = issued[port] + n;
   endtask

   task automatic push_iss(input logic [2:0] g, input logic wr, input logic [11:0] addr,
                           input logic [31:0] wdata, input int gap);
      iss_t e;
      e.grant = g; e.wr = wr; e.addr = addr; e.wdata = wdata; e.gap = gap;
      iss_q.push_back(e);
   endtask

   task automatic push_rsp(input logic [3:0] ack, input logic err, input logic [31:0] rdata,
                           input int lat);
      rsp_t e;
      e.ack = ack; e.err = err; e.rdata = rdata; e.lat = lat;
      rsp_q.push_back(e);
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while ((iss_q.size() != 0 || rsp_q.size() != 0 || pend_any()) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (iss_q.size() != 0 || rsp_q.size() != 0 || pend_any())
         fail(name, 64'(iss_q.size() + rsp_q.size()));
   endtask

   // Requester model: m_req stays high while a port has unretired work.
   initial begin
      logic [NREQ-1:0] ack_s;
      m_req = '0;
      for (int i = 0; i < NREQ; i++) served[i] = 0;
      forever begin
         @(negedge clk);
         ack_s = m_ack;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (ack_s[i] === 1'b1) served[i] = served[i] + 1;
            m_req[i] = (issued[i] > served[i] + aborted[i]);
         end
      end
   end

   // Slave model: acks slv_delay cycles after regreq and checks the command stayed stable.
   initial begin
      logic        s_wr;
      logic [11:0] s_addr;
      logic [31:0] s_wdata;
      regack = 1'b0; regerr = 1'b0; regrdata = '0;
      forever begin
         @(negedge clk);
         if (regreq === 1'b1 && rst === 1'b0) begin
            s_wr = regwr; s_addr = regaddr; s_wdata = regwdata;
            repeat (slv_delay) @(posedge clk);
            #1;
            regack   = 1'b1;
            regerr   = (s_addr == 12'hFFC);
            regrdata = {12'h000, s_addr, 8'h00};
            @(negedge clk);
            if (slv_chk) begin
               chk("hold_regwr", 64'(regwr), 64'(s_wr));
               chk("hold_regaddr", 64'(regaddr), 64'(s_addr));
               chk("hold_regwdata", 64'(regwdata), 64'(s_wdata));
            end
            @(posedge clk);
            #1;
            regack = 1'b0; regerr = 1'b0; regrdata = '0;
         end
      end
   end

   // Issue monitor: compares each regreq against the expected command queue.
   initial begin
      int   t_last  = 0;
      bit   pending = 1'b0;
      iss_t e;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            pending = 1'b0;
         end else begin
            if (regreq === 1'b1) begin
               chk("regreq_overlap", 64'(pending), 64'(0));
               if (iss_q.size() == 0) begin
                  fail("unexpected_regreq", 64'(regaddr));
               end else begin
                  e = iss_q.pop_front();
                  chk("grant", 64'(grant), 64'(e.grant));
                  chk("regwr", 64'(regwr), 64'(e.wr));
                  chk("regaddr", 64'(regaddr), 64'(e.addr));
                  chk("regwdata", 64'(regwdata), 64'(e.wdata));
                  if (e.gap > 0) chk("regreq_gap", 64'(cyc - t_last), 64'(e.gap));
               end
               t_last  = cyc;
               t_req   = cyc;
               pending = 1'b1;
            end
            if (regack === 1'b1) pending = 1'b0;
         end
      end
   end

   // Response monitor: compares each m_ack against the expected response queue.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && m_ack !== '0) begin
            if (rsp_q.size() == 0) begin
               fail("unexpected_m_ack", 64'(m_ack));
            end else begin
               r = rsp_q.pop_front();
               chk("m_ack", 64'(m_ack), 64'(r.ack));
               chk("m_err", 64'(m_err), 64'(r.err));
               chk("m_rdata", 64'(m_rdata), 64'(r.rdata));
               chk("ack_latency", 64'(cyc - t_req), 64'(r.lat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; tmo_clr = 1'b0;
      m_wr = '0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         issued[i] = 0;
         aborted[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_m_ack", 64'(m_ack), 64'(0));
      chk("rst_regreq", 64'(regreq), 64'(0));
      chk("rst_grant", 64'(grant), 64'(0));
      chk("rst_tmo_flag", 64'(tmo_flag), 64'(0));

      // all four requesting, zero-wait slave: grants 0,1,2,3,0,1 every 4 cycles
      slv_delay = 1;
      req(0, 1'b0, 12'h100, 32'h0, 2);
      req(1, 1'b0, 12'h104, 32'h0, 2);
      req(2, 1'b0, 12'h108, 32'h0, 1);
      req(3, 1'b0, 12'h10C, 32'h0, 1);
      push_iss(3'd0, 1'b0, 12'h100, 32'h0, 0);
      push_iss(3'd1, 1'b0, 12'h104, 32'h0, 4);
      push_iss(3'd2, 1'b0, 12'h108, 32'h0, 4);
      push_iss(3'd3, 1'b0, 12'h10C, 32'h0, 4);
      push_iss(3'd0, 1'b0, 12'h100, 32'h0, 4);
      push_iss(3'd1, 1'b0, 12'h104, 32'h0, 4);
      push_rsp(4'b0001, 1'b0, 32'h0001_0000, 2);
      push_rsp(4'b0010, 1'b0, 32'h0001_0400, 2);
      push_rsp(4'b0100, 1'b0, 32'h0001_0800, 2);
      push_rsp(4'b1000, 1'b0, 32'h0001_0C00, 2);
      push_rsp(4'b0001, 1'b0, 32'h0001_0000, 2);
      push_rsp(4'b0010, 1'b0, 32'h0001_0400, 2);
      wait_done(100, "rr_sequence_done");

      // single read on port 2, slave acks 3 cycles after regreq
      slv_delay = 3;
      req(2, 1'b0, 12'h004, 32'h0, 1);
      push_iss(3'd2, 1'b0, 12'h004, 32'h0, 0);
      push_rsp(4'b0100, 1'b0, 32'h0000_0400, 4);
      wait_done(50, "single_read_done");
      repeat (3) @(negedge clk);
      chk("hold_m_rdata", 64'(m_rdata), 64'h400);
      chk("hold_m_err", 64'(m_err), 64'(0));

      // slave never acks in time; late ack arrives 10 cycles after the timeout response
      slv_delay = 267;
      slv_chk   = 1'b0;
      req(0, 1'b0, 12'h020, 32'h0, 1);
      push_iss(3'd0, 1'b0, 12'h020, 32'h0, 0);
      push_rsp(4'b0001, 1'b1, 32'hDEADBEEF, 257);
      wait_done(400, "timeout_done");
      chk("tmo_flag_set", 64'(tmo_flag), 64'(1));
      repeat (20) @(negedge clk);
      chk("late_ack_m_ack", 64'(m_ack), 64'(0));
      chk("late_ack_m_err", 64'(m_err), 64'(1));
      chk("late_ack_m_rdata", 64'(m_rdata), 64'hDEADBEEF);
      chk("tmo_flag_sticky", 64'(tmo_flag), 64'(1));
      tmo_clr = 1'b1;
      @(negedge clk);
      tmo_clr = 1'b0;
      chk("tmo_flag_clr", 64'(tmo_flag), 64'(0));

      // reset while waiting for the slave; slave acks after reset
      slv_delay = 4;
      req(3, 1'b0, 12'h030, 32'h0, 1);
      push_iss(3'd3, 1'b0, 12'h030, 32'h0, 0);
      n = 0;
      while (iss_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (iss_q.size() != 0) fail("reset_test_regreq", 64'(n));
      aborted[3] = aborted[3] + 1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_m_err", 64'(m_err), 64'(0));
      chk("rst_mid_regaddr", 64'(regaddr), 64'(0));
      chk("rst_mid_grant", 64'(grant), 64'(0));
      repeat (6) @(negedge clk);
      chk("post_late_m_ack", 64'(m_ack), 64'(0));
      chk("post_late_m_rdata", 64'(m_rdata), 64'(0));
      chk("post_late_m_err", 64'(m_err), 64'(0));
      chk("post_late_regreq", 64'(regreq), 64'(0));
      chk("post_late_regwr", 64'(regwr), 64'(0));
      chk("post_late_regwdata", 64'(regwdata), 64'(0));
      chk("post_late_tmo_flag", 64'(tmo_flag), 64'(0));

      // write on port 1 contending with port 3 right after reset: port 1 first
      slv_delay = 3;
      slv_chk   = 1'b1;
      req(1, 1'b1, 12'h014, 32'h0000_0005, 1);
      req(3, 1'b0, 12'hFFC, 32'h0, 1);
      push_iss(3'd1, 1'b1, 12'h014, 32'h0000_0005, 0);
      push_iss(3'd3, 1'b0, 12'hFFC, 32'h0, 6);
      push_rsp(4'b0010, 1'b0, 32'h0000_1400, 4);
      push_rsp(4'b1000, 1'b1, 32'h000F_FC00, 4);
      wait_done(60, "write_contend_done");
      repeat (5) @(negedge clk);
      chk("final_m_rdata_hold", 64'(m_rdata), 64'h000F_FC00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
